// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: IDLE/PLAY/DEAD sequencer with BCD pipe-pass score and best-score tracking.
// Best tracking is built only when FLAPPY_HIGH_SCORE_EN is defined.
module flappy_game_ctrl #(
   parameter int DEAD_TICKS = 48,
   parameter int CW         = 12
) (
   input  logic          clk,
   input  logic          arst_i,
   input  logic          i_physics_stb,
   input  logic          i_flap,
   input  logic          i_bird_die,
   input  logic [CW-1:0] i_bird_x1,
   input  logic [CW-1:0] i_pipe_x2,
   output logic [1:0]    o_state,
   output logic          o_play_en,
   output logic          o_world_rst,
   output logic [11:0]   o_score_bcd,
   output logic [11:0]   o_best_bcd,
   output logic          o_new_best
);
   typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DEAD = 2'b10} state_t;
   localparam logic [7:0] LP_TICKS = 8'(DEAD_TICKS);

   state_t      r_state, w_next;
   logic [7:0]  r_ticks;
   logic        r_scored;
   logic [11:0] r_score, w_score_inc;
   logic        w_start, w_die_edge, w_passed;

   assign w_start     = (r_state == IDLE) && i_flap;
   assign w_die_edge  = (r_state == PLAY) && i_bird_die;
   assign w_passed    = i_pipe_x2 < i_bird_x1;
   assign o_state     = r_state;
   assign o_score_bcd = r_score;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = i_flap ? PLAY : IDLE;
         PLAY:    w_next = i_bird_die ? DEAD : PLAY;
         DEAD:    w_next = (i_flap && r_ticks == 8'd0) ? IDLE : DEAD;
         default: w_next = IDLE;
      endcase
   end

   // BCD +1 with ripple carry; 999 holds
   always_comb begin
      w_score_inc = r_score;
      if (r_score != 12'h999) begin
         if (r_score[3:0] != 4'd9) w_score_inc[3:0] = r_score[3:0] + 4'd1;
         else begin
            w_score_inc[3:0] = 4'd0;
            if (r_score[7:4] != 4'd9) w_score_inc[7:4] = r_score[7:4] + 4'd1;
            else begin
               w_score_inc[7:4]  = 4'd0;
               w_score_inc[11:8] = r_score[11:8] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge arst_i) begin
      if (arst_i) begin
         r_state     <= IDLE;
         o_play_en   <= 1'b0;
         o_world_rst <= 1'b1;
         r_score     <= 12'h000;
         r_scored    <= 1'b0;
         r_ticks     <= 8'd0;
      end else begin
         r_state     <= w_next;
         o_play_en   <= (w_next == PLAY);
         o_world_rst <= (w_next == IDLE);
         if (w_start) begin
            r_score  <= 12'h000;
            r_scored <= 1'b0;
         end else if (r_state == PLAY && !i_bird_die && i_physics_stb) begin
            if (!w_passed) r_scored <= 1'b0;
            else if (!r_scored) begin
               r_score  <= w_score_inc;
               r_scored <= 1'b1;
            end
         end
         if (w_die_edge) r_ticks <= LP_TICKS;
         else if (r_state == DEAD && i_physics_stb && r_ticks != 8'd0) r_ticks <= r_ticks - 8'd1;
      end
   end

`ifdef FLAPPY_HIGH_SCORE_EN
   logic [11:0] r_best;
   logic        r_new_best;

   assign o_best_bcd = r_best;
   assign o_new_best = r_new_best;

   // packed BCD orders the same as the decimal value, so a plain compare suffices
   always_ff @(posedge clk or posedge arst_i) begin
      if (arst_i) begin
         r_best     <= 12'h000;
         r_new_best <= 1'b0;
      end else begin
         r_new_best <= w_die_edge && (r_score > r_best);
         if (w_die_edge && (r_score > r_best)) r_best <= r_score;
      end
   end
`else
   assign o_best_bcd = 12'h000;
   assign o_new_best = 1'b0;
`endif
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed and random play checked against an integer-score game model.
module tb_flappy_game_ctrl;
   localparam int DT = 4;
   localparam int CW = 12;
`ifdef FLAPPY_HIGH_SCORE_EN
   localparam bit HS = 1'b1;
`else
   localparam bit HS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          arst_i = 1'b1;
   logic          flap = 1'b0, stb = 1'b0, die = 1'b0;
   logic [CW-1:0] bird = 12'd160, pipe = 12'd200;
   logic [1:0]    o_state;
   logic          o_play_en, o_world_rst, o_new_best;
   logic [11:0]   o_score_bcd, o_best_bcd;

   always #5 clk = ~clk;

   flappy_game_ctrl #(.DEAD_TICKS(DT), .CW(CW)) dut (
      .clk(clk), .arst_i(arst_i), .i_physics_stb(stb), .i_flap(flap), .i_bird_die(die),
      .i_bird_x1(bird), .i_pipe_x2(pipe), .o_state(o_state), .o_play_en(o_play_en),
      .o_world_rst(o_world_rst), .o_score_bcd(o_score_bcd), .o_best_bcd(o_best_bcd),
      .o_new_best(o_new_best)
   );

   typedef struct packed {
      logic [1:0]  st;
      logic        pe;
      logic        wr;
      logic [11:0] sc;
      logic [11:0] bs;
      logic        nb;
   } exp_t;

   exp_t q[$];
   int   vecs = 0, miss = 0;
   int   m_st, m_score, m_best, m_cnt;
   bit   m_scored, m_nb;

   function automatic logic [11:0] to_bcd(input int v);
      return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
   endfunction

   task automatic model_reset();
      m_st = 0; m_score = 0; m_best = 0; m_cnt = 0; m_scored = 0; m_nb = 0;
   endtask

   task automatic cyc(input bit f, input bit s, input bit d, input int b, input int p);
      @(negedge clk);
      flap = f; stb = s; die = d; bird = CW'(b); pipe = CW'(p);
      m_nb = 0;
      case (m_st)
         0: if (f) begin m_st = 1; m_score = 0; m_scored = 0; end
         1: if (d) begin
               m_st = 2; m_cnt = DT;
               if (HS && m_score > m_best) begin m_best = m_score; m_nb = 1; end
            end else if (s) begin
               if (p < b) begin
                  if (!m_scored) begin
                     if (m_score < 999) m_score++;
                     m_scored = 1;
                  end
               end else m_scored = 0;
            end
         default: if (f && m_cnt == 0) m_st = 0;
                  else if (s && m_cnt > 0) m_cnt--;
      endcase
      q.push_back('{st: 2'(m_st), pe: (m_st == 1), wr: (m_st == 0), sc: to_bcd(m_score),
                    bs: to_bcd(m_best), nb: m_nb});
   endtask

   task automatic pass();
      cyc(0, 1, 0, 160, 200);
      cyc(0, 1, 0, 160, 150);
   endtask

   task automatic dead_out();
      repeat (DT) cyc(0, 1, 0, 160, 150);
      cyc(1, 0, 0, 160, 150);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      arst_i = 1'b1; flap = 0; stb = 0; die = 0;
      #1;
      vecs++;
      if ({o_state, o_world_rst, o_play_en, o_score_bcd, o_best_bcd, o_new_best} !== 29'h0400_0000) begin
         miss++;
         $display("FAIL async_reset act st=%0d wr=%b pe=%b sc=%h bs=%h nb=%b exp st=0 wr=1 pe=0 sc=000 bs=000 nb=0",
                  o_state, o_world_rst, o_play_en, o_score_bcd, o_best_bcd, o_new_best);
      end
      model_reset();
      @(negedge clk);
      arst_i = 1'b0;
   endtask

   initial begin : monitor
      exp_t e, a;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = '{st: o_state, pe: o_play_en, wr: o_world_rst, sc: o_score_bcd, bs: o_best_bcd, nb: o_new_best};
            vecs++;
            if (a !== e) begin
               miss++;
               $display("FAIL vec%0d act st=%0d pe=%b wr=%b sc=%h bs=%h nb=%b exp st=%0d pe=%b wr=%b sc=%h bs=%h nb=%b",
                        vecs, a.st, a.pe, a.wr, a.sc, a.bs, a.nb, e.st, e.pe, e.wr, e.sc, e.bs, e.nb);
            end
         end
      end
   end

   initial begin : driver
      model_reset();
      repeat (3) @(negedge clk);
      arst_i = 1'b0;
      repeat (3) cyc(0, 0, 0, 160, 200);
      // round A: first pass, hold, reach 3, die on a qualifying tick
      cyc(1, 0, 0, 160, 200);
      pass();
      repeat (10) cyc(0, 1, 0, 160, 150);
      pass(); pass();
      cyc(0, 1, 0, 160, 200);
      cyc(0, 1, 1, 160, 150);
      repeat (3) cyc(0, 1, 0, 160, 150);
      cyc(1, 0, 0, 160, 150);
      cyc(1, 1, 0, 160, 150);
      cyc(1, 0, 0, 160, 150);
      cyc(0, 0, 0, 160, 200);
      // round B: lower score leaves best alone
      cyc(1, 0, 0, 160, 200);
      pass(); pass();
      cyc(0, 0, 1, 160, 200);
      dead_out();
      // round C: carries and saturation
      cyc(1, 0, 0, 160, 200);
      repeat (1001) pass();
      cyc(0, 0, 1, 160, 200);
      dead_out();
      cyc(1, 0, 0, 160, 200);
      pass(); pass();
      mid_reset();
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
             int'($urandom_range(100, 220)),
             ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(100, 220)));
         if (i == 1500) mid_reset();
      end
      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         miss++;
         $display("FAIL drain act pending=%0d exp pending=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
